// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizing for the FIFO read-side packer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    FLUSH
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_COUNT = 4;

endpackage

// File: rtl/fifo_rd_packer.sv
// FIFO read-port consumer: pops entries while the FIFO is non-empty and packs
// PACK_COUNT of them into one word on a valid/ready output slot.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_COUNT = DEF_PACK_COUNT,
  localparam int CNT_W = $clog2(PACK_COUNT + 1)
) (
  input  logic                             rclk,
  input  logic                             rrst,
  input  logic                             empty,
  input  logic [DATA_WIDTH-1:0]            data_out,
  output logic                             r_en,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data,
  output logic [CNT_W-1:0]                 out_cnt,
  output logic [15:0]                      word_count
);

  localparam logic [CNT_W-1:0] PACK_FULL = CNT_W'(PACK_COUNT);

  typedef logic [PACK_COUNT-1:0][DATA_WIDTH-1:0] acc_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_cap;
  logic [CNT_W:0]   fill_sum;
  logic             inflight;
  logic             slot_free;
  logic             load;
  acc_t             acc, acc_d, word_d;

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    load      = 1'b0;
    word_d    = '0;
    slot_free = !out_valid || out_ready;
    fill_sum  = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight};
    r_en      = !rrst && (state == FILL) && !empty && (fill_sum < {1'b0, PACK_FULL});

    // A read issued last cycle lands in lane cnt regardless of state.
    for (int unsigned i = 0; i < PACK_COUNT; i++) begin
      if (inflight && (cnt == CNT_W'(i))) acc_d[i] = data_out;
    end
    cnt_cap = inflight ? cnt + CNT_W'(1) : cnt;
    cnt_d   = cnt_cap;

    unique case (state)
      FILL: begin
        if (inflight && (cnt_cap == PACK_FULL)) begin
          if (slot_free) begin
            load  = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = HOLD;
          end
        end else if (flush && ((cnt != '0) || inflight)) begin
          state_d = FLUSH;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FLUSH: begin
        if (!inflight && slot_free) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Lanes beyond the captured count are zeroed so partial words are clean.
    for (int unsigned i = 0; i < PACK_COUNT; i++) begin
      if (CNT_W'(i) < cnt_cap) word_d[i] = acc_d[i];
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= FILL;
      cnt        <= '0;
      inflight   <= 1'b0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_cnt    <= '0;
      word_count <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      inflight <= r_en;
      acc      <= acc_d;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word_d;
        out_cnt   <= cnt_cap;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && (word_count != 16'hFFFF)) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a registered-empty FIFO read-port model.
module tb_fifo_rd_packer;
  import fifo_rd_pkg::*;

  localparam int DW = 8;
  localparam int PC = 4;
  localparam int CW = $clog2(PC + 1);
  localparam int OW = DW * PC;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          empty = 1'b1;
  logic [DW-1:0] data_out = '0;
  logic          r_en;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic [15:0]   word_count;

  logic [DW-1:0] fq[$];
  logic          sparse = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_COUNT(PC)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .empty      (empty),
    .data_out   (data_out),
    .r_en       (r_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_cnt    (out_cnt),
    .word_count (word_count)
  );

  // FIFO read port: data one cycle after r_en, junk otherwise; empty registered.
  always @(posedge rclk) begin
    if (r_en && fq.size() != 0) data_out <= fq.pop_front();
    else data_out <= 8'hEE;
    if (fq.size() == 0) empty <= 1'b1;
    else if (sparse) empty <= ~empty;
    else empty <= 1'b0;
  end

  task automatic push(input logic [DW-1:0] v);
    fq.push_back(v);
  endtask

  task automatic do_reset;
    rrst = 1'b1; flush = 1'b0; sparse = 1'b0; out_ready = 1'b0;
    fq.delete();
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic test_reset;
    rrst = 1'b1; flush = 1'b0; out_ready = 1'b0; sparse = 1'b0;
    push(8'h10); push(8'h20);
    for (int c = 0; c < 3; c++) begin
      @(negedge rclk);
      n_checks++;
      if (r_en !== 1'b0) begin n_fail++; $display("FAIL reset_r_en c%0d: got %b want 0", c, r_en); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid c%0d: got %b want 0", c, out_valid); end
      n_checks++;
      if (word_count !== 16'd0) begin n_fail++; $display("FAIL reset_word_count c%0d: got %0d want 0", c, word_count); end
      n_checks++;
      if (out_data !== '0 || out_cnt !== '0) begin
        n_fail++; $display("FAIL reset_out_data c%0d: got %h/%0d want 0/0", c, out_data, out_cnt);
      end
    end
    fq.delete();
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic test_basic_pack;
    int reads = 0, first_rd = -1, last_rd = -1, vcyc = 0, first_v = -1;
    logic [OW-1:0] word = '0;
    logic [CW-1:0] wcnt = '0;
    do_reset();
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      if (r_en) begin reads++; if (first_rd < 0) first_rd = c; last_rd = c; end
      if (out_valid) begin vcyc++; if (first_v < 0) begin first_v = c; word = out_data; wcnt = out_cnt; end end
    end
    n_checks++;
    if (reads != 4 || last_rd - first_rd != 3) begin
      n_fail++; $display("FAIL basic_reads: got %0d reads span %0d want 4 span 3", reads, last_rd - first_rd);
    end
    n_checks++;
    if (vcyc != 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", vcyc); end
    n_checks++;
    if (first_v != last_rd + 2) begin n_fail++; $display("FAIL basic_latency: valid at %0d want %0d", first_v, last_rd + 2); end
    n_checks++;
    if (word !== 32'h44332211 || wcnt !== CW'(4)) begin
      n_fail++; $display("FAIL basic_word: got %h/%0d want 44332211/4", word, wcnt);
    end
    n_checks++;
    if (word_count !== 16'd1) begin n_fail++; $display("FAIL basic_word_count: got %0d want 1", word_count); end
  endtask

  task automatic test_back_pressure;
    int reads = 0, bad = 0;
    logic seen = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int c = 0; c < 30; c++) begin
      @(negedge rclk);
      if (r_en) reads++;
      if (out_valid) begin
        seen = 1'b1;
        if (out_data !== 32'h04030201 || out_cnt !== CW'(4)) bad++;
      end else if (seen) bad++;
    end
    n_checks++;
    if (!seen || bad != 0) begin n_fail++; $display("FAIL bp_hold_stable: seen %b unstable %0d want 1/0", seen, bad); end
    n_checks++;
    if (reads != 8 || r_en !== 1'b0) begin n_fail++; $display("FAIL bp_reads: got %0d r_en %b want 8/0", reads, r_en); end
    n_checks++;
    if (dut.state !== HOLD) begin n_fail++; $display("FAIL bp_state: got %0d want %0d", dut.state, HOLD); end
    n_checks++;
    if (word_count !== 16'd0) begin n_fail++; $display("FAIL bp_count0: got %0d want 0", word_count); end
    out_ready = 1'b1;
    @(negedge rclk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h08070605 || out_cnt !== CW'(4)) begin
      n_fail++; $display("FAIL bp_second: got v%b %h/%0d want v1 08070605/4", out_valid, out_data, out_cnt);
    end
    n_checks++;
    if (word_count !== 16'd1) begin n_fail++; $display("FAIL bp_count1: got %0d want 1", word_count); end
    @(negedge rclk);
    n_checks++;
    if (out_valid !== 1'b0 || word_count !== 16'd2) begin
      n_fail++; $display("FAIL bp_drain: got v%b cnt %0d want v0 cnt 2", out_valid, word_count);
    end
  endtask

  task automatic test_sparse;
    int viol = 0, reads = 0, vcyc = 0;
    logic [OW-1:0] word = '0;
    do_reset();
    sparse = 1'b1; out_ready = 1'b1;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk);
      if (r_en && empty) viol++;
      if (r_en) reads++;
      if (out_valid) begin vcyc++; word = out_data; end
    end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL sparse_r_en_empty: got %0d violations want 0", viol); end
    n_checks++;
    if (reads != 4 || vcyc != 1) begin n_fail++; $display("FAIL sparse_counts: got %0d reads %0d words want 4/1", reads, vcyc); end
    n_checks++;
    if (word !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL sparse_word: got %h want a3a2a1a0", word); end
  endtask

  task automatic test_flush;
    int vcyc = 0, reads = 0;
    logic found = 1'b0, got = 1'b0;
    logic [OW-1:0] word = '0;
    logic [CW-1:0] wcnt = '0;
    do_reset();
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    for (int c = 0; c < 4; c++) begin @(negedge rclk); if (out_valid) vcyc++; end
    n_checks++;
    if (vcyc != 0) begin n_fail++; $display("FAIL flush_idle_ignored: got %0d valid cycles want 0", vcyc); end
    push(8'hAA); push(8'hBB); push(8'hCC);
    for (int c = 0; c < 10 && !found; c++) begin @(negedge rclk); if (r_en) found = 1'b1; end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL flush_first_read: got timeout want r_en"); end
    @(negedge rclk);
    n_checks++;
    if (r_en !== 1'b1) begin n_fail++; $display("FAIL flush_second_read: got %b want 1", r_en); end
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (out_valid) begin got = 1'b1; word = out_data; wcnt = out_cnt; end
      else begin
        if (r_en) reads++;
        @(negedge rclk);
      end
    end
    n_checks++;
    if (reads != 0) begin n_fail++; $display("FAIL flush_no_reads: got %0d reads want 0", reads); end
    n_checks++;
    if (!got || word !== 32'h0000BBAA || wcnt !== CW'(2)) begin
      n_fail++; $display("FAIL flush_word: got v%b %h/%0d want v1 0000bbaa/2", got, word, wcnt);
    end
  endtask

  task automatic test_reset_mid_word;
    logic found = 1'b0, got = 1'b0;
    logic [OW-1:0] word = '0;
    logic [CW-1:0] wcnt = '0;
    do_reset();
    out_ready = 1'b1;
    push(8'h91); push(8'h92);
    for (int c = 0; c < 10 && !found; c++) begin @(negedge rclk); if (r_en) found = 1'b1; end
    repeat (3) @(negedge rclk);
    n_checks++;
    if (!found || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_setup: got found %b valid %b want 1/0", found, out_valid); end
    rrst = 1'b1;
    @(negedge rclk);
    n_checks++;
    if (r_en !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_in_reset: got r_en %b valid %b want 0/0", r_en, out_valid); end
    rrst = 1'b0;
    push(8'h5A); push(8'h5B); push(8'h5C); push(8'h5D);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge rclk);
      if (out_valid) begin got = 1'b1; word = out_data; wcnt = out_cnt; end
    end
    n_checks++;
    if (!got || word !== 32'h5D5C5B5A || wcnt !== CW'(4)) begin
      n_fail++; $display("FAIL midrst_word: got v%b %h/%0d want v1 5d5c5b5a/4", got, word, wcnt);
    end
    @(negedge rclk);
    n_checks++;
    if (word_count !== 16'd1) begin n_fail++; $display("FAIL midrst_word_count: got %0d want 1", word_count); end
  endtask

  initial begin
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_pack();
    test_back_pressure();
    test_sparse();
    test_flush();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
